// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller between the core memory stage and
// a single-port word RAM with a ready/rvalid handshake.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   req_en_M, req_we_M  access request and store/load select from the core
//   addr_M, wdata_M     byte address and LSB-aligned store data
//   size_M, unsigned_M  access size (byte/half/word) and load zero-extension
//   rdata_M             formatted load data (held until the next load capture)
//   stall_M             holds the core while an access is outstanding
//   err_M               one-cycle pulse for misaligned / reserved-size requests
//   mem_req, mem_we     RAM request and write enable
//   mem_addr, mem_be    word address and byte enables
//   mem_wdata           lane-replicated store data
//   mem_ready           RAM accepts the request this cycle
//   mem_rvalid, mem_rdata  RAM read response
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en_M,
  input  logic        req_we_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  input  logic [1:0]  size_M,
  input  logic        unsigned_M,
  output logic [31:0] rdata_M,
  output logic        stall_M,
  output logic        err_M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        bad_req;
  logic [3:0]  be_raw;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_fmt;

  // Request check on the live core inputs: reserved size or an address not
  // aligned to the access size never reaches the RAM.
  always_comb begin
    bad_req = 1'b0;
    unique case (size_M)
      2'b00:   bad_req = 1'b0;
      2'b01:   bad_req = addr_M[0];
      2'b10:   bad_req = |addr_M[1:0];
      default: bad_req = 1'b1;
    endcase
  end

  // Byte enables and replicated store data from the latched request. Loads
  // use the same enable pattern as stores.
  always_comb begin
    be_raw    = 4'b1111;
    mem_wdata = wdata_q;
    unique case (size_q)
      2'b00: begin
        be_raw    = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_raw    = addr_q[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        be_raw    = 4'b1111;
        mem_wdata = wdata_q;
      end
    endcase
  end

  // Load lane select and sign/zero extension of the returned RAM word.
  always_comb begin
    ld_b   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_h   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_fmt = mem_rdata;
    unique case (size_q)
      2'b00:   ld_fmt = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'b01:   ld_fmt = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ld_fmt = mem_rdata;
    endcase
  end

  // Next-state and latched-field logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_en_M) begin
          err_d = bad_req;
          if (bad_req) begin
            state_d = S_DONE;
          end else begin
            we_d    = req_we_M;
            addr_d  = addr_M;
            wdata_d = wdata_M;
            size_d  = size_M;
            uns_d   = unsigned_M;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) state_d = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = ld_fmt;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM side is decoded from state only, so reset drops it immediately.
  assign mem_req  = (state_q == S_REQ);
  assign mem_we   = (state_q == S_REQ) & we_q;
  assign mem_be   = (state_q == S_REQ) ? be_raw : 4'b0000;
  assign mem_addr = {addr_q[31:2], 2'b00};

  // Stall is combinational on req_en_M so the core is held in the very
  // cycle it first presents a request.
  assign stall_M = req_en_M & (state_q != S_DONE);
  assign err_M   = (state_q == S_DONE) & err_q;
  assign rdata_M = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized bench for dmem_ctrl. A word-array RAM model acts
// as the memory and as the reference for load results; expected enables,
// store lanes, load values and stall lengths come from byte-level arithmetic.
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_en_M = 1'b0, req_we_M = 1'b0, unsigned_M = 1'b0;
  logic [31:0] addr_M = 32'd0, wdata_M = 32'd0;
  logic [1:0]  size_M = 2'd0;
  logic [31:0] rdata_M, mem_addr, mem_wdata;
  logic        stall_M, err_M, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int          total = 0, bad = 0;
  logic [31:0] ram [256];
  logic [31:0] last_rd;

  dmem_ctrl dut (
    .clk(clk), .rst(rst), .req_en_M(req_en_M), .req_we_M(req_we_M),
    .addr_M(addr_M), .wdata_M(wdata_M), .size_M(size_M), .unsigned_M(unsigned_M),
    .rdata_M(rdata_M), .stall_M(stall_M), .err_M(err_M), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_bad(logic [31:0] a, logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    return (int'(a[1:0]) % (1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(int off, int n);
    return 4'(((1 << n) - 1) << off);
  endfunction

  // Lane i carries store byte (i mod size) -- replication across the word.
  function automatic logic [31:0] exp_wdata(logic [31:0] wd, int n);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(logic [31:0] word, int off, int n, logic uns);
    logic [31:0] v, m;
    m = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
    v = (word >> (8*off)) & m;
    if (!uns && n < 4 && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  // One core access with a RAM that accepts after rdy refusals and answers
  // a load in the rv-th wait cycle. Unrelated inputs are scrambled while the
  // access is outstanding, and stray rvalid/rdata are thrown at the REQ phase.
  task automatic run_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] sz, input logic uns, input int rdy, input int rv);
    int   n, off, idx, stalls, reqs, wcnt, exp_st;
    logic acc, done, bd;
    n = 1 << sz; off = int'(a[1:0]); idx = int'(a[9:2]); bd = is_bad(a, sz);
    exp_st = bd ? 1 : (we ? 2 + rdy : 2 + rdy + rv);
    stalls = 0; reqs = 0; wcnt = 0; acc = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    req_en_M = 1'b1; req_we_M = we; addr_M = a; wdata_M = wd; size_M = sz; unsigned_M = uns;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!stall_M) begin
        done = 1'b1;
        if (!bd && !we) last_rd = exp_load(ram[idx], off, n, uns);
        if (!bd && we)
          for (int i = 0; i < 4; i++)
            if (i >= off && i < off + n) ram[idx][8*i +: 8] = wd[8*(i-off) +: 8];
        chk("stall_cycles", stalls, exp_st);
        chk("err_done", err_M, bd);
        chk("rdata", rdata_M, last_rd);
        chk("req_cycles", reqs, bd ? 0 : rdy + 1);
        chk("req_in_done", mem_req, 1'b0);
      end else begin
        stalls++;
        chk("err_stall", err_M, 1'b0);
        if (mem_req) begin
          reqs++;
          chk("mem_addr", mem_addr, {a[31:2], 2'b00});
          chk("mem_be", mem_be, exp_be(off, n));
          chk("mem_we", mem_we, we);
          if (we) chk("mem_wdata", mem_wdata, exp_wdata(wd, n));
          mem_ready = (reqs > rdy); acc = mem_ready;
          mem_rvalid = 1'($urandom); mem_rdata = $urandom;
          addr_M = $urandom; wdata_M = $urandom; size_M = 2'($urandom);
          unsigned_M = 1'($urandom); req_we_M = 1'($urandom);
        end else if (acc) begin
          wcnt++;
          mem_ready = 1'b0; mem_rdata = ram[idx]; mem_rvalid = (wcnt == rv);
          addr_M = $urandom; wdata_M = $urandom; size_M = 2'($urandom);
          unsigned_M = 1'($urandom);
        end
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    req_en_M = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    last_rd = 32'd0;

    // Reset state, with stall following req_en_M while held in reset.
    #12;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_be", mem_be, 4'd0);
    chk("rst_err", err_M, 1'b0);
    chk("rst_rdata", rdata_M, 32'd0);
    chk("rst_stall0", stall_M, 1'b0);
    req_en_M = 1'b1; #1;
    chk("rst_stall1", stall_M, 1'b1);
    req_en_M = 1'b0;
    @(negedge clk); rst = 1'b1;

    // Directed scenarios.
    run_access(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1);
    ram[128] = 32'h80112233;
    run_access(1'b0, 32'h203, 32'd0, 2'd0, 1'b0, 0, 2);
    chk("byte_load_s", rdata_M, 32'hFFFFFF80);
    ram[128] = 32'h8001ABCD;
    run_access(1'b0, 32'h202, 32'd0, 2'd1, 1'b1, 0, 1);
    chk("half_load_u", rdata_M, 32'h00008001);
    run_access(1'b1, 32'h202, 32'h1234, 2'd1, 1'b0, 0, 1);
    chk("half_store_ram", ram[128], 32'h1234ABCD);
    run_access(1'b0, 32'h101, 32'd0, 2'd2, 1'b0, 0, 1);
    run_access(1'b0, 32'h000, 32'd0, 2'd3, 1'b0, 0, 1);
    run_access(1'b1, 32'h044, 32'h0BADF00D, 2'd2, 1'b0, 5, 1);
    run_access(1'b0, 32'h044, 32'd0, 2'd2, 1'b0, 5, 3);
    chk("slow_ready_load", rdata_M, 32'h0BADF00D);

    // Randomized traffic with occasional idle gaps.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("idle_stall", stall_M, 1'b0);
        chk("idle_req", mem_req, 1'b0);
      end
      run_access(1'($urandom), 32'($urandom_range(0, 1023)), $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end

    // Reset while waiting for read data; a late rvalid must be ignored.
    ram[128] = 32'h80112233;
    run_access(1'b0, 32'h203, 32'd0, 2'd0, 1'b0, 0, 1);
    @(posedge clk); #1;
    req_en_M = 1'b1; req_we_M = 1'b0; addr_M = 32'h204; size_M = 2'd2; unsigned_M = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("r43_req", mem_req, 1'b1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("r43_wait_req", mem_req, 1'b0);
    chk("r43_wait_stall", stall_M, 1'b1);
    rst = 1'b0; #1;
    chk("r43_rst_req", mem_req, 1'b0);
    chk("r43_rst_be", mem_be, 4'd0);
    chk("r43_rst_rdata", rdata_M, 32'd0);
    chk("r43_rst_stall", stall_M, 1'b1);
    req_en_M = 1'b0; #1;
    chk("r43_rst_stall0", stall_M, 1'b0);
    last_rd = 32'd0;
    @(negedge clk);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    repeat (2) begin
      @(negedge clk);
      chk("r43_late_rdata", rdata_M, 32'd0);
      chk("r43_late_stall", stall_M, 1'b0);
    end
    mem_rvalid = 1'b0;
    run_access(1'b0, 32'h203, 32'd0, 2'd0, 1'b1, 1, 1);
    chk("after_rst_load", rdata_M, 32'h00000080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
